// File: rtl/ioblock_ser.sv
// ioblock_ser: parallel-to-serial stage driving an IO block's OUT/TS inputs over a valid/ready handshake.
// Define IOBLOCK_SER_PARITY_EN to append an even-parity bit to every frame.
module ioblock_ser #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 0,
    parameter bit IDLE_LEVEL = 0
) (
    input  logic             IOCLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             OUT,
    output logic             TS,
    output logic             BUSY,
    output logic             DONE
);
`ifdef IOBLOCK_SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] load_sh;
    logic [WIDTH-1:0] step_sh;
    logic             last;
    logic             accept;
    logic             first_bit;
    logic             data_bit;
    logic             next_bit;
    assign last      = state == SHIFT && cnt == LAST;
    assign DIN_READY = !RST && (state == IDLE || last);
    assign accept    = DIN_VALID && DIN_READY;
    // The first bit goes straight to OUT at the accept edge, so the shift register holds only what remains.
    assign first_bit = MSB_FIRST ? DIN[WIDTH-1] : DIN[0];
    assign load_sh   = MSB_FIRST ? DIN << 1 : DIN >> 1;
    assign step_sh   = MSB_FIRST ? sh << 1 : sh >> 1;
    assign data_bit  = MSB_FIRST ? sh[WIDTH-1] : sh[0];
`ifdef IOBLOCK_SER_PARITY_EN
    logic par;
    always_ff @(posedge IOCLK) begin
        if (RST)
            par <= 1'b0;
        else if (accept)
            par <= ^DIN;
    end
    assign next_bit = cnt == CW'(WIDTH - 1) ? par : data_bit;
`else
    assign next_bit = data_bit;
`endif
    always_ff @(posedge IOCLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            OUT   <= IDLE_LEVEL;
            TS    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
            sh    <= load_sh;
            OUT   <= first_bit;
            TS    <= 1'b1;
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
        end else if (last) begin
            state <= IDLE;
            cnt   <= '0;
            OUT   <= IDLE_LEVEL;
            TS    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else if (state == SHIFT) begin
            cnt   <= cnt + 1'b1;
            sh    <= step_sh;
            OUT   <= next_bit;
            DONE  <= cnt == LAST - 1'b1;
        end
    end
endmodule

// File: tb/tb_ioblock_ser.sv
// tb_ioblock_ser: directed checks of LSB-first (idle low) and MSB-first (idle high) instances driven in lockstep.
module tb_ioblock_ser;
`ifdef IOBLOCK_SER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    logic       IOCLK = 1'b0;
    logic       RST = 1'b1;
    logic       DIN_VALID = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       rdy0, out0, ts0, busy0, done0;
    logic       rdy1, out1, ts1, busy1, done1;
    int         checks = 0;
    int         errors = 0;

    ioblock_ser #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(0)) u0 (
        .IOCLK(IOCLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy0),
        .OUT(out0), .TS(ts0), .BUSY(busy0), .DONE(done0)
    );
    ioblock_ser #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1)) u1 (
        .IOCLK(IOCLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy1),
        .OUT(out1), .TS(ts1), .BUSY(busy1), .DONE(done1)
    );

    always #5 IOCLK = ~IOCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge IOCLK);
        #1;
    endtask

    task automatic idle_chk(input string tag, input logic rdy);
        chk({tag, ".ts0"}, ts0, 0);
        chk({tag, ".ts1"}, ts1, 0);
        chk({tag, ".out0"}, out0, 0);
        chk({tag, ".out1"}, out1, 1);
        chk({tag, ".busy0"}, busy0, 0);
        chk({tag, ".busy1"}, busy1, 0);
        chk({tag, ".done0"}, done0, 0);
        chk({tag, ".rdy0"}, rdy0, rdy);
        chk({tag, ".rdy1"}, rdy1, rdy);
    endtask

    // Called in cycle 0 of a frame; leaves the bench one edge past the frame's last cycle.
    task automatic frame(input string tag, input logic [7:0] w, input logic hold,
                         input logic nv, input logic [7:0] nw);
        logic eb0, eb1, lst;
        int   j;
        for (int i = 0; i < FL; i++) begin
            j   = 7 - i;
            eb0 = (i < 8) ? w[i] : ^w;
            eb1 = (i < 8) ? w[j] : ^w;
            lst = i == FL - 1;
            chk($sformatf("%s.out0[%0d]", tag, i), out0, eb0);
            chk($sformatf("%s.out1[%0d]", tag, i), out1, eb1);
            chk($sformatf("%s.ts0[%0d]", tag, i), ts0, 1);
            chk($sformatf("%s.ts1[%0d]", tag, i), ts1, 1);
            chk($sformatf("%s.busy0[%0d]", tag, i), busy0, 1);
            chk($sformatf("%s.done0[%0d]", tag, i), done0, lst);
            chk($sformatf("%s.done1[%0d]", tag, i), done1, lst);
            chk($sformatf("%s.rdy0[%0d]", tag, i), rdy0, lst);
            if (lst) begin
                DIN_VALID = nv;
                DIN = nw;
            end else begin
                DIN_VALID = hold;
                DIN = 8'h5A ^ 8'(i);
            end
            tick();
        end
    endtask

    initial begin
        DIN_VALID = 1'b1;
        DIN = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_chk($sformatf("rst%0d", i), 0);
        end
        RST = 1'b0;
        DIN_VALID = 1'b0;
        tick();
        idle_chk("idle", 1);
        DIN = 8'hA5;
        DIN_VALID = 1'b1;
        tick();
        frame("a5", 8'hA5, 0, 0, 8'h00);
        idle_chk("a5_end", 1);
        DIN = 8'h0F;
        DIN_VALID = 1'b1;
        tick();
        frame("b2b0f", 8'h0F, 1, 1, 8'hF0);
        frame("b2bf0", 8'hF0, 1, 0, 8'h00);
        idle_chk("b2b_end", 1);
        DIN = 8'h80;
        DIN_VALID = 1'b1;
        tick();
        frame("h80", 8'h80, 0, 0, 8'h00);
        DIN = 8'hFF;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort.ts0[%0d]", i), ts0, 1);
            chk($sformatf("abort.out0[%0d]", i), out0, 1);
            tick();
        end
        RST = 1'b1;
        chk("abort.rdy_in_rst", rdy0, 0);
        tick();
        idle_chk("abort", 0);
        RST = 1'b0;
        tick();
        idle_chk("post_abort", 1);
        DIN = 8'h3C;
        DIN_VALID = 1'b1;
        tick();
        frame("h3c", 8'h3C, 0, 0, 8'h00);
        DIN = 8'h07;
        DIN_VALID = 1'b1;
        tick();
        frame("h07", 8'h07, 0, 1, 8'h03);
        frame("h03", 8'h03, 0, 0, 8'h00);
        idle_chk("final", 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
